pc: RTL and testbench

//   Program counter for the CPU fetch stage. Holds the current instruction address (PCAddr)
//   and updates it once per clock under a 3-bit PCDrive command from the control unit:

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_next.sv | 49 ++++
 rtl/pc.sv | 49 ++++
 tb/tb_pc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: PCDrive command codes
// and the helper that classifies which commands update the address.
package pc_pkg;

    typedef logic [2:0] pc_drive_t;

    localparam pc_drive_t PC_HOLD = 3'b000;
    localparam pc_drive_t PC_INC  = 3'b001;
    localparam pc_drive_t PC_VEC  = 3'b010;
    localparam pc_drive_t PC_LOAD = 3'b011;
    localparam pc_drive_t PC_REL  = 3'b100;

    // Reserved codes 101..111 behave like HOLD and never raise the fetch strobe.
    function automatic logic drive_updates(input pc_drive_t drive);
        logic upd;
        case (drive)
            PC_INC, PC_VEC, PC_LOAD, PC_REL: upd = 1'b1;
            default:                         upd = 1'b0;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-address logic for the program counter.
// Optional macro PC_ALIGN_EN forces LOAD/REL results onto a STEP boundary.
module pc_next
    import pc_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = {WIDTH{1'b0}},
    parameter int                 STEP      = 4
) (
    input  logic [WIDTH-1:0] PCAddr,
    input  logic [WIDTH-1:0] PCSet,
    input  pc_drive_t        PCDrive,
    output logic [WIDTH-1:0] next_addr,
    output logic             update
);

    logic [WIDTH-1:0] rel_sum_s;
    logic [WIDTH-1:0] load_tgt_s;
    logic [WIDTH-1:0] rel_tgt_s;

    // Two's-complement add covers both forward and backward branches; wrap is silent.
    assign rel_sum_s = PCAddr + PCSet;

`ifdef PC_ALIGN_EN
    localparam int               ALIGN_BITS = (STEP > 1) ? $clog2(STEP) : 0;
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((({{(WIDTH-1){1'b0}}, 1'b1}) << ALIGN_BITS) - {{(WIDTH-1){1'b0}}, 1'b1});

    assign load_tgt_s = PCSet & ALIGN_MASK;
    assign rel_tgt_s  = rel_sum_s & ALIGN_MASK;
`else
    assign load_tgt_s = PCSet;
    assign rel_tgt_s  = rel_sum_s;
`endif

    // Decode the drive command into the address to be registered on the next edge.
    always_comb begin
        next_addr = PCAddr;
        update    = drive_updates(PCDrive);
        case (PCDrive)
            PC_INC:  next_addr = PCAddr + WIDTH'(STEP);
            PC_VEC:  next_addr = RESET_VEC;
            PC_LOAD: next_addr = load_tgt_s;
            PC_REL:  next_addr = rel_tgt_s;
            default: next_addr = PCAddr;
        endcase
    end

endmodule

// File: rtl/pc.sv
// Fetch-stage program counter: registered address plus one-cycle fetch strobe.
// Build option: define PC_ALIGN_EN to force STEP alignment of LOAD/REL targets.
module pc
    import pc_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = {WIDTH{1'b0}},
    parameter int                 STEP      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCSet,
    input  pc_drive_t        PCDrive,
    output logic [WIDTH-1:0] PCAddr,
    output logic             GetInstruction
);

    logic [WIDTH-1:0] next_addr_s;
    logic             update_s;
    logic [WIDTH-1:0] pc_addr_r;
    logic             get_instr_r;

    pc_next #(
        .WIDTH     (WIDTH),
        .RESET_VEC (RESET_VEC),
        .STEP      (STEP)
    ) u_next (
        .PCAddr    (pc_addr_r),
        .PCSet     (PCSet),
        .PCDrive   (PCDrive),
        .next_addr (next_addr_s),
        .update    (update_s)
    );

    // Address and strobe registers; rst is active-low and overrides any command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_addr_r   <= RESET_VEC;
            get_instr_r <= 1'b0;
        end else begin
            pc_addr_r   <= next_addr_s;
            get_instr_r <= update_s;
        end
    end

    assign PCAddr         = pc_addr_r;
    assign GetInstruction = get_instr_r;

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: stimulus pushes expected {PCAddr, GetInstruction},
// a monitor pops and compares one entry after each clock edge or async-reset probe.
module tb_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCSet;
    logic [2:0]  PCDrive;
    logic [31:0] PCAddr;
    logic        GetInstruction;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        get;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    event sample_ev;

`ifdef PC_ALIGN_EN
    localparam logic [31:0] E_LD1  = 32'd5788;
    localparam logic [31:0] E_LD2  = 32'd7892;
    localparam logic [31:0] E_INC1 = 32'd7896;
    localparam logic [31:0] E_INC2 = 32'd7900;
    localparam logic [31:0] E_REL1 = 32'd7932;
    localparam logic [31:0] E_REL2 = 32'd7896;
    localparam logic [31:0] E_LD3  = 32'd1232;
`else
    localparam logic [31:0] E_LD1  = 32'd5791;
    localparam logic [31:0] E_LD2  = 32'd7894;
    localparam logic [31:0] E_INC1 = 32'd7898;
    localparam logic [31:0] E_INC2 = 32'd7902;
    localparam logic [31:0] E_REL1 = 32'd7935;
    localparam logic [31:0] E_REL2 = 32'd7900;
    localparam logic [31:0] E_LD3  = 32'd1234;
`endif

    pc dut (
        .clk            (clk),
        .rst            (rst),
        .PCSet          (PCSet),
        .PCDrive        (PCDrive),
        .PCAddr         (PCAddr),
        .GetInstruction (GetInstruction)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string n, input logic [31:0] a, input logic g);
        exp_t e;
        e.name = n;
        e.addr = a;
        e.get  = g;
        sb.push_back(e);
    endtask

    task automatic cmd(input string n, input logic [2:0] d, input logic [31:0] s,
                       input logic [31:0] a, input logic g);
        @(negedge clk);
        PCDrive = d;
        PCSet   = s;
        push_exp(n, a, g);
    endtask

    // Monitor: one scoreboard entry per clock edge or explicit async probe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (PCAddr !== e.addr) begin
                    bad++;
                    $display("FAIL %s PCAddr got=%0d (0x%08h) exp=%0d (0x%08h)",
                             e.name, PCAddr, PCAddr, e.addr, e.addr);
                end
                total++;
                if (GetInstruction !== e.get) begin
                    bad++;
                    $display("FAIL %s GetInstruction got=%0b exp=%0b",
                             e.name, GetInstruction, e.get);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired with %0d pending entries", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        PCDrive = 3'b011;
        PCSet   = 32'h1234_5678;
        #2;
        push_exp("rst_t0", 32'd0, 1'b0);
        ->sample_ev;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_exp("rst_held", 32'd0, 1'b0);
        end

        @(negedge clk);
        rst     = 1'b1;
        PCDrive = 3'b000;
        push_exp("release_hold", 32'd0, 1'b0);

        cmd("load5791",  3'b011, 32'd5791, E_LD1, 1'b1);
        cmd("hold5791",  3'b000, 32'd0,    E_LD1, 1'b0);
        cmd("load7894",  3'b011, 32'd7894, E_LD2, 1'b1);
        cmd("inc1",      3'b001, 32'd7894, E_INC1, 1'b1);
        cmd("inc2",      3'b001, 32'd7894, E_INC2, 1'b1);
        cmd("rel_p33",   3'b100, 32'd33,   E_REL1, 1'b1);
        cmd("rel_m35",   3'b100, 32'hFFFF_FFDD, E_REL2, 1'b1);

        cmd("load_top",  3'b011, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        cmd("inc_wrap",  3'b001, 32'd0,    32'd0, 1'b1);
        cmd("load1234",  3'b011, 32'd1234, E_LD3, 1'b1);
        cmd("vec",       3'b010, 32'd999,  32'd0, 1'b1);
        cmd("vec_again", 3'b010, 32'd0,    32'd0, 1'b1);
        cmd("rel_zero",  3'b100, 32'd0,    32'd0, 1'b1);
        cmd("load100",   3'b011, 32'd100,  32'd100, 1'b1);
        cmd("rsv101",    3'b101, 32'd8,    32'd100, 1'b0);
        cmd("rsv110",    3'b110, 32'd8,    32'd100, 1'b0);
        cmd("rsv111",    3'b111, 32'd8,    32'd100, 1'b0);
        cmd("inc104",    3'b001, 32'd0,    32'd104, 1'b1);
        cmd("inc108",    3'b001, 32'd0,    32'd108, 1'b1);

        @(negedge clk);
        PCDrive = 3'b001;
        #2;
        rst = 1'b0;
        push_exp("async_rst", 32'd0, 1'b0);
        ->sample_ev;

        @(negedge clk);
        push_exp("async_held", 32'd0, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        push_exp("resume4", 32'd4, 1'b1);
        cmd("resume8", 3'b001, 32'd0, 32'd8, 1'b1);
        cmd("final_hold", 3'b000, 32'd0, 32'd8, 1'b0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
